// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg (package)
// Purpose  : Shared types and constants for the registered ripple adder.
//            DEFAULT_WIDTH - default operand width of registered_adder_ovf
//            nibble_t      - 4-bit operand/sum type
//            adder_result_t- packed {sum, carry} pair for a 4-bit add
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [3:0] nibble_t;

  typedef struct packed {
    nibble_t sum;
    logic    carry;
  } adder_result_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : One-bit full adder cell used to build the ripple-carry chain.
// Ports    : a, b   - input bits
//            cin    - carry in
//            s      - sum bit
//            cout   - carry out
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/registered_adder_ovf.sv
`default_nettype none
// ============================================================================
// Module   : registered_adder_ovf
// Purpose  : Unsigned ripple-carry adder with registered sum, carry-out
//            overflow flag, output-valid strobe and sticky overflow flag.
//            Latency is one clock from valid_i to valid_o.
// Ports    : clk_i             - rising-edge clock
//            rst_i             - synchronous active-high reset
//            valid_i           - capture a_i/b_i on this edge
//            a_i, b_i          - unsigned operands, WIDTH bits
//            sum_o             - registered sum (mod 2^WIDTH, or saturated)
//            overflow_o        - registered carry-out of the captured sum
//            valid_o           - sum_o/overflow_o updated on the last edge
//            overflow_sticky_o - set by any captured overflow, cleared by reset
// Config   : ADDER_SATURATE_EN - when defined, an overflowing capture stores
//                                all ones in sum_o instead of the wrapped sum
// Revision : 1.0 - initial release
// ============================================================================
module registered_adder_ovf
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             overflow_o,
  output logic             valid_o,
  output logic             overflow_sticky_o
);

  // Ripple chain: carry[0] is the fixed carry-in, carry[WIDTH] the carry-out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a_i[i]),
      .b    (b_i[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  logic             w_overflow;
  logic [WIDTH-1:0] w_sum_sel;

  assign w_overflow = w_carry[WIDTH];

`ifdef ADDER_SATURATE_EN
  assign w_sum_sel = w_overflow ? {WIDTH{1'b1}} : w_sum;
`else
  assign w_sum_sel = w_sum;
`endif

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic             sticky_q, sticky_d;

  // Operands are only looked at when valid_i is high, so unknown operands
  // on idle cycles cannot reach any register.
  always_comb begin
    sum_d      = sum_q;
    overflow_d = overflow_q;
    valid_d    = valid_i;
    sticky_d   = sticky_q;
    if (valid_i) begin
      sum_d      = w_sum_sel;
      overflow_d = w_overflow;
      sticky_d   = sticky_q | w_overflow;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      sticky_q   <= sticky_d;
    end
  end

  assign sum_o             = sum_q;
  assign overflow_o        = overflow_q;
  assign valid_o           = valid_q;
  assign overflow_sticky_o = sticky_q;

endmodule : registered_adder_ovf
`default_nettype wire

// File: tb/tb_registered_adder_ovf.sv
`default_nettype none
// ============================================================================
// Module   : tb_registered_adder_ovf
// Purpose  : Directed self-checking bench for registered_adder_ovf (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_registered_adder_ovf;
  import adder_pkg::*;

`ifdef ADDER_SATURATE_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  logic    clk_i = 1'b0;
  logic    rst_i;
  logic    valid_i;
  nibble_t a_i;
  nibble_t b_i;
  nibble_t sum_o;
  logic    overflow_o;
  logic    valid_o;
  logic    overflow_sticky_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  registered_adder_ovf #(.WIDTH(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .a_i               (a_i),
    .b_i               (b_i),
    .sum_o             (sum_o),
    .overflow_o        (overflow_o),
    .valid_o           (valid_o),
    .overflow_sticky_o (overflow_sticky_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, then advance to just after the next rising edge.
  task automatic step(input logic rst, input logic v, input nibble_t a, input nibble_t b);
    rst_i   = rst;
    valid_i = v;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(input string tag, input nibble_t s, input logic o,
                         input logic v, input logic st);
    chk({tag, ".sum"},    {28'd0, sum_o},     {28'd0, s});
    chk({tag, ".ovf"},    {31'd0, overflow_o}, {31'd0, o});
    chk({tag, ".valid"},  {31'd0, valid_o},    {31'd0, v});
    chk({tag, ".sticky"}, {31'd0, overflow_sticky_o}, {31'd0, st});
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0;
    #2;

    // Reset with random operands and valid_i high: reset wins.
    step(1'b1, 1'b1, nibble_t'($urandom_range(15)), nibble_t'($urandom_range(15)));
    step(1'b1, 1'b1, nibble_t'($urandom_range(15)), nibble_t'($urandom_range(15)));
    chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 4'b0101, 4'b0011);
    chk_all("add_5_3", 4'b1000, 1'b0, 1'b1, 1'b0);

    // Unsigned carry-out set; signed sense would not matter.
    step(1'b0, 1'b1, 4'b1100, 4'b0100);
    chk_all("add_c_4", c_SAT ? 4'b1111 : 4'b0000, 1'b1, 1'b1, 1'b1);

    step(1'b0, 1'b1, 4'b1100, 4'b0011);
    chk_all("add_c_3", 4'b1111, 1'b0, 1'b1, 1'b1);

    step(1'b0, 1'b1, 4'b1111, 4'b0001);
    chk_all("wrap_f_1", c_SAT ? 4'b1111 : 4'b0000, 1'b1, 1'b1, 1'b1);

    // Idle with unknown operands: outputs hold, valid_o drops.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
      chk_all($sformatf("idle%0d", i), c_SAT ? 4'b1111 : 4'b0000, 1'b1, 1'b0, 1'b1);
    end

    // Back-to-back captures.
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    chk_all("b2b_1_1", 4'b0010, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0111, 4'b0001);
    chk_all("b2b_7_1", 4'b1000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 4'b1111);
    chk_all("b2b_f_f", c_SAT ? 4'b1111 : 4'b1110, 1'b1, 1'b1, 1'b1);

    // Reset mid-stream discards the capture presented on that edge.
    step(1'b1, 1'b1, 4'b1001, 4'b1001);
    chk_all("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Sticky stays clear on a non-overflowing capture after reset.
    step(1'b0, 1'b1, 4'b0011, 4'b0100);
    chk_all("post_rst", 4'b0111, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_registered_adder_ovf
`default_nettype wire
